// File: rtl/adder_pipe_pkg.sv
// Shared definitions for the chunked, pipelined add/subtract unit.
// Holds the operation encoding and helpers that map an op onto B inversion and carry-in.
package adder_pipe_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ADDC = 2'b10,
    OP_SUBB = 2'b11
  } op_e;

  function automatic logic op_inverts_b(input op_e op);
    return (op == OP_SUB) || (op == OP_SUBB);
  endfunction

  // For subtract ops a carry-in of 1 means "no borrow pending".
  function automatic logic op_carry_in(input op_e op, input logic cin);
    case (op)
      OP_ADD:  return 1'b0;
      OP_SUB:  return 1'b1;
      default: return cin;
    endcase
  endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// One pipeline stage: resolves CHUNK result bits from the registered carry of the
// previous stage and forwards operands and partial result to the next stage.
module adder_pipe_stage #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_carry,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf
);

  localparam int LO  = IDX * CHUNK;
  localparam int MSB = CHUNK - 1;

  logic [CHUNK-1:0] a_c;
  logic [CHUNK-1:0] b_c;
  logic [CHUNK-1:0] s_c;
  logic             c_out;
  logic             c_msb;
  logic [WIDTH-1:0] next_sum;

  always_comb begin
    a_c = in_a[LO +: CHUNK];
    b_c = in_b[LO +: CHUNK];
    {c_out, s_c} = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, in_carry};
    // Carry into the chunk MSB recovered from the MSB sum bit, no second adder.
    c_msb = s_c[MSB] ^ a_c[MSB] ^ b_c[MSB];
    next_sum = in_sum;
    next_sum[LO +: CHUNK] = s_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_sum   <= '0;
      out_carry <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (en) begin
      out_valid <= in_valid;
      out_a     <= in_a;
      out_b     <= in_b;
      out_sum   <= next_sum;
      out_carry <= c_out;
      out_ovf   <= c_msb ^ c_out;
    end
  end

endmodule

// File: rtl/adder_pipe.sv
// WIDTH-bit add/subtract pipelined in CHUNK-bit slices; latency WIDTH/CHUNK cycles,
// one beat per cycle, whole pipeline stalls together under output backpressure.
module adder_pipe
  import adder_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTAGE = WIDTH / CHUNK;

  // Handshake: a beat transfers on any rising edge where valid && ready are both 1.
  // Producers hold valid and data stable until the transfer; ready never depends on
  // the valid of the same interface, so a pop and a push may occur in one cycle.
  logic             en;
  logic             v_s     [NSTAGE+1];
  logic [WIDTH-1:0] a_s     [NSTAGE+1];
  logic [WIDTH-1:0] b_s     [NSTAGE+1];
  logic [WIDTH-1:0] sum_s   [NSTAGE+1];
  logic             carry_s [NSTAGE+1];
  logic             ovf_s   [NSTAGE];
  op_e              op_in;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign op_in    = op_e'(op);

  assign v_s[0]     = in_valid;
  assign a_s[0]     = a;
  assign b_s[0]     = op_inverts_b(op_in) ? ~b : b;
  assign sum_s[0]   = '0;
  assign carry_s[0] = op_carry_in(op_in, cin);

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    adder_pipe_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .IDX   (k)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_valid  (v_s[k]),
      .in_a      (a_s[k]),
      .in_b      (b_s[k]),
      .in_sum    (sum_s[k]),
      .in_carry  (carry_s[k]),
      .out_valid (v_s[k+1]),
      .out_a     (a_s[k+1]),
      .out_b     (b_s[k+1]),
      .out_sum   (sum_s[k+1]),
      .out_carry (carry_s[k+1]),
      .out_ovf   (ovf_s[k])
    );
  end

  assign out_valid = v_s[NSTAGE];
  assign sum       = sum_s[NSTAGE];
  assign cout      = carry_s[NSTAGE];
  assign ovf       = ovf_s[NSTAGE-1];

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe (WIDTH=8, CHUNK=4): directed vectors, stall, reset and
// randomized traffic checked against an integer-arithmetic reference model.
module tb_adder_pipe;

  localparam int W   = 8;
  localparam int C   = 4;
  localparam int NST = W / C;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   op;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_cmp = 0;
  int n_err = 0;

  adder_pipe #(.WIDTH(W), .CHUNK(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Reference: {ovf, cout, sum} from plain signed/unsigned integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic [1:0] opv, input logic cv);
    longint md = 64'sd1 << W;
    longint ua = longint'(av);
    longint ub = longint'(bv);
    longint sa = (ua >= md / 2) ? ua - md : ua;
    longint sb = (ub >= md / 2) ? ub - md : ub;
    longint r;
    longint sr;
    longint extra;
    logic   co;
    logic   ov;
    if (opv[0] == 1'b0) begin
      extra = (opv == 2'b00) ? 0 : longint'(cv);
      r  = ua + ub + extra;
      sr = sa + sb + extra;
      co = (r >= md);
    end else begin
      extra = (opv == 2'b01) ? 0 : longint'(!cv);
      r  = ua - ub - extra;
      sr = sa - sb - extra;
      co = (r >= 0);
    end
    ov = (sr < -(md / 2)) || (sr >= md / 2);
    return {ov, co, W'(r & (md - 1))};
  endfunction

  task automatic drive_idle();
    in_valid = 1'b0;
    a = '0;
    b = '0;
    op = 2'b00;
    cin = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({ovf, cout, sum} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got ovf=%b cout=%b sum=%h want all 0", ovf, cout, sum);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [7] = '{8'd12, 8'd255, 8'd127, 8'd5, 8'h80, 8'hF0, 8'h10};
    logic [W-1:0] tb [7] = '{8'd7, 8'd1, 8'd1, 8'd7, 8'h01, 8'h0F, 8'h10};
    logic [1:0]   to [7] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b11};
    logic         tc [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] es [7] = '{8'd19, 8'd0, 8'd128, 8'hFE, 8'h7F, 8'h00, 8'hFF};
    logic         ec [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic         eo [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    int lat;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = 1'b1;
      a = ta[i];
      b = tb[i];
      op = to[i];
      cin = tc[i];
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL dir%0d_in_ready: got %b want 1", i, in_ready);
      end
      @(negedge clk);
      drive_idle();
      lat = 1;
      while (out_valid !== 1'b1 && lat < 8) begin
        @(negedge clk);
        lat++;
      end
      n_cmp++;
      if (lat !== NST) begin
        n_err++;
        $display("FAIL dir%0d_latency: got %0d cycles want %0d", i, lat, NST);
      end
      n_cmp++;
      if ({ovf, cout, sum} !== {eo[i], ec[i], es[i]}) begin
        n_err++;
        $display("FAIL dir%0d_result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                 i, sum, cout, ovf, es[i], ec[i], eo[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_stall();
    logic [W+1:0] exp_q[$];
    logic [W+1:0] held;
    logic [W+1:0] e;
    logic [W-1:0] ba [4];
    logic [W-1:0] bb [4];
    logic [1:0]   bo [4];
    logic         bc [4];
    bit           have_held = 0;
    int           sent = 0;
    int           got = 0;
    for (int i = 0; i < 4; i++) begin
      ba[i] = W'($urandom);
      bb[i] = W'($urandom);
      bo[i] = 2'($urandom_range(0, 3));
      bc[i] = 1'($urandom_range(0, 1));
    end
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      if (sent < 4) begin
        in_valid = 1'b1;
        a = ba[sent];
        b = bb[sent];
        op = bo[sent];
        cin = bc[sent];
      end else begin
        drive_idle();
      end
      out_ready = (cyc < 2) || (cyc >= 12);
      #1;
      if (out_valid && !out_ready) begin
        n_cmp++;
        if (in_ready !== 1'b0) begin
          n_err++;
          $display("FAIL stall_in_ready: cycle %0d got %b want 0", cyc, in_ready);
        end
        if (have_held) begin
          n_cmp++;
          if ({ovf, cout, sum} !== held) begin
            n_err++;
            $display("FAIL stall_hold: cycle %0d got %h want %h", cyc, {ovf, cout, sum}, held);
          end
        end
        held = {ovf, cout, sum};
        have_held = 1;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, op, cin));
        sent++;
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL stall_extra_beat: got %h want none", {ovf, cout, sum});
        end else begin
          e = exp_q.pop_front();
          if ({ovf, cout, sum} !== e) begin
            n_err++;
            $display("FAIL stall_order: beat %0d got %h want %h", got, {ovf, cout, sum}, e);
          end
        end
        got++;
      end
      @(posedge clk);
    end
    n_cmp++;
    if (got !== 4 || sent !== 4) begin
      n_err++;
      $display("FAIL stall_count: got %0d out / %0d in want 4 / 4", got, sent);
    end
    @(negedge clk);
    drive_idle();
    out_ready = 1'b1;
  endtask

  task automatic test_reset_midflight();
    int seen = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = W'($urandom);
      b = W'($urandom) | W'(1);
      op = 2'($urandom_range(0, 3));
      cin = 1'b1;
    end
    @(negedge clk);
    drive_idle();
    out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_out_valid: got %b want 0", out_valid);
    end
    n_cmp++;
    if ({ovf, cout, sum} !== '0) begin
      n_err++;
      $display("FAIL midrst_outputs: got ovf=%b cout=%b sum=%h want all 0", ovf, cout, sum);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL midrst_stale: got %0d stale output cycles want 0", seen);
    end
  endtask

  task automatic test_random(input string name, input int n, input int valid_pct, input int stall_pct);
    logic [W+1:0] exp_q[$];
    logic [W+1:0] e;
    logic [W+1:0] held;
    bit           stalled = 0;
    bit           took = 0;
    int           sent = 0;
    int           got = 0;
    int           cyc = 0;
    int           limit = n * 10 + 100;
    while ((sent < n || got < n) && cyc < limit) begin
      @(negedge clk);
      if (!in_valid || took) begin
        if (sent < n && $urandom_range(0, 99) < valid_pct) begin
          in_valid = 1'b1;
          a = W'($urandom);
          b = W'($urandom);
          op = 2'($urandom_range(0, 3));
          cin = 1'($urandom_range(0, 1));
        end else begin
          drive_idle();
        end
      end
      out_ready = ($urandom_range(0, 99) >= stall_pct);
      #1;
      n_cmp++;
      if (in_ready !== (!out_valid || out_ready)) begin
        n_err++;
        $display("FAIL %s_in_ready: cycle %0d got %b want %b", name, cyc, in_ready, !out_valid || out_ready);
      end
      if (stalled) begin
        n_cmp++;
        if (out_valid !== 1'b1 || {ovf, cout, sum} !== held) begin
          n_err++;
          $display("FAIL %s_hold: cycle %0d got v=%b %h want v=1 %h", name, cyc, out_valid, {ovf, cout, sum}, held);
        end
      end
      stalled = out_valid && !out_ready;
      held = {ovf, cout, sum};
      took = in_valid && in_ready;
      if (took) begin
        exp_q.push_back(model(a, b, op, cin));
        sent++;
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL %s_extra_beat: got %h want none", name, {ovf, cout, sum});
        end else begin
          e = exp_q.pop_front();
          if ({ovf, cout, sum} !== e) begin
            n_err++;
            $display("FAIL %s_result: beat %0d got %h want %h", name, got, {ovf, cout, sum}, e);
          end
        end
        got++;
      end
      cyc++;
      @(posedge clk);
    end
    n_cmp++;
    if (sent !== n || got !== n || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL %s_count: got %0d in / %0d out want %0d / %0d", name, sent, got, n, n);
    end
    if (stall_pct == 0 && valid_pct == 100) begin
      n_cmp++;
      if (cyc > n + NST) begin
        n_err++;
        $display("FAIL %s_throughput: got %0d cycles want <= %0d", name, cyc, n + NST);
      end
    end
    @(negedge clk);
    drive_idle();
    out_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    drive_idle();
    test_reset();
    test_directed();
    test_stall();
    test_random("back_to_back", 64, 100, 0);
    test_reset_midflight();
    test_random("random", 10000, 80, 30);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adder_pipe.md
ADDER_PIPE -- requirements
Module: adder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width in bits, multiple of CHUNK, 4..64.
REQ-002 SHALL have parameter CHUNK, default 4: bits resolved per pipeline stage; NSTAGE = WIDTH/CHUNK.
REQ-003 SHALL have port clk  in  1: single clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1: reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  in  1: operand beat valid.
REQ-006 SHALL have port in_ready  out  1: block accepts beat this cycle.
REQ-007 SHALL have port a  in  WIDTH: operand A, unsigned/two's complement.
REQ-008 SHALL have port b  in  WIDTH: operand B.
REQ-009 SHALL have port op  in  2: 00 add, 01 sub, 10 add+cin, 11 sub-with-borrow.
REQ-010 SHALL have port cin  in  1: carry/borrow input, used only for op 10/11.
REQ-011 SHALL have port out_valid  out  1: result beat valid.
REQ-012 SHALL have port out_ready  in  1: downstream accepts result.
REQ-013 SHALL have port sum  out  WIDTH: result.
REQ-014 SHALL have port cout  out  1: carry out of MSB (for sub: 1 = no borrow).
REQ-015 SHALL have port ovf  out  1: signed two's-complement overflow.

Function
REQ-016 Arithmetic SHALL be: op00 A+B+0; op01 A+~B+1; op10 A+B+cin; op11 A+~B+cin (cin=1 means no borrow pending).
REQ-017 ovf SHALL be carry-into-MSB XOR carry-out-of-MSB of the final stage.
REQ-018 Stage k (0..NSTAGE-1) SHALL compute result bits [k*CHUNK +: CHUNK] from the carry registered by stage k-1; operand upper chunks and lower result chunks SHALL travel with the beat.
REQ-019 Beat accepted when in_valid && in_ready; its result SHALL appear on out_valid exactly NSTAGE cycles later absent stalls.
REQ-020 Pipeline enable en = !out_valid || out_ready; in_ready SHALL equal en (combinational, no dependence on in_valid).
REQ-021 When en=0 all stage registers and valids SHALL hold; sum/cout/ovf SHALL remain stable while out_valid && !out_ready.
REQ-022 When en=1 each stage valid SHALL load from the previous stage; bubbles (in_valid=0) SHALL propagate as invalid stages.
REQ-023 Throughput SHALL be one beat per cycle with out_ready held high.
REQ-024 Simultaneous output pop and input push in one cycle SHALL both succeed.
REQ-025 Wrap-around: results SHALL be modulo 2^WIDTH, carry reported only on cout.
REQ-026 sum/cout/ovf contents while out_valid=0 are don't-care but SHALL NOT be X after reset.

Reset
REQ-027 On rst=1 at a clock edge all stage valid bits SHALL clear; out_valid=0 next cycle.
REQ-028 On reset sum, cout, ovf and all stage data registers SHALL clear to 0.
REQ-029 in_ready SHALL be 1 in the first cycle after reset release.
REQ-030 Reset mid-operation SHALL discard all in-flight beats; none SHALL emerge afterwards.

Structure
REQ-031 Package adder_pipe_pkg SHALL hold the op encoding type and constants OP_ADD, OP_SUB, OP_ADDC, OP_SUBB.
REQ-032 One sub-module adder_pipe_stage (CHUNK-bit add with carry in/out and pass-through registers) SHALL be instantiated NSTAGE times via generate.
REQ-033 No multi-cycle or latch paths; carry chain per cycle SHALL be at most CHUNK bits.

Verification (WIDTH=8, CHUNK=4, latency 2)
REQ-034 a=12, b=7, op=00 -> 2 cycles later sum=19, cout=0, ovf=0.
REQ-035 a=255, b=1, op=00 -> sum=0, cout=1, ovf=0; a=127, b=1 -> sum=128, ovf=1.
REQ-036 a=5, b=7, op=01 -> sum=0xFE, cout=0, ovf=0; a=0x80, b=1, op=01 -> sum=0x7F, ovf=1.
REQ-037 Stream 4 beats back-to-back with out_ready=0 from cycle 2 -> in_ready=0, out_valid and sum held; release -> all 4 results in order, no loss or duplicate.
REQ-038 a=0xF0, b=0x0F, op=10, cin=1 -> sum=0x00, cout=1; op=11, a=0x10, b=0x10, cin=0 -> sum=0xFF, cout=0.
REQ-039 Assert rst with 2 beats in flight -> out_valid=0 next cycle, sum=0, no stale beat appears; random add/sub vs reference model, 10k beats with random backpressure.
